// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encoding and stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DATA   = 3'd2,
        FLUSH  = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// 8-to-32 big-endian shift register; word_valid flags the byte that
// completes a word, and {shift, data} is that complete word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift;
    logic [1:0]  idx;

    assign word       = {shift, data};
    assign word_valid = load && (idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift <= '0;
            idx   <= '0;
        end else if (load) begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of statement order inside the block.
            shift <= {shift[15:0], data};
            idx   <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word count plus big-endian words from a byte
// stream, writes them to instruction memory, then releases the Processor.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic                  proc_reset,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [16:0] DEPTH = 17'(1 << ADDR_WIDTH);

    state_t      state;
    logic [15:0] count;
    logic [15:0] header;
    logic        transfer;
    logic [31:0] word;
    logic        word_valid;

    assign in_ready = (state == CNT_HI) || (state == CNT_LO) || (state == DATA);
    assign transfer = in_valid && in_ready;
    assign header   = {count[15:8], in_data};

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .load       (transfer && (state == DATA)),
        .data       (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= CNT_HI;
            count        <= '0;
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            proc_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; only a completed word raises it.
            we <= 1'b0;
            case (state)
                CNT_HI: begin
                    if (transfer) begin
                        count[15:8] <= in_data;
                        state       <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (transfer) begin
                        count[7:0] <= in_data;
                        if (header == 16'd0) begin
                            state      <= RUN;
                            proc_reset <= 1'b0;
                            done       <= 1'b1;
                        end else if ({1'b0, header} > DEPTH) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        we           <= 1'b1;
                        wdata        <= word;
                        waddr        <= words_loaded[ADDR_WIDTH-1:0];
                        words_loaded <= words_loaded + 16'd1;
                        if (words_loaded == count - 16'd1) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Release the Processor only after the last write cycle.
                    state      <= RUN;
                    proc_reset <= 1'b0;
                    done       <= 1'b1;
                end
                RUN, ERR: begin
                end
                default: state <= CNT_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams with random stalls are
// compared against a word-list model derived from the stream format.
module tb_imem_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          proc_reset;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;

    int total = 0;
    int bad   = 0;

    logic [7:0]      stream[$];
    logic [AW+31:0]  got_w[$];
    logic [AW+31:0]  exp_w[$];
    bit              exp_done;
    bit              exp_err;
    int              exp_n;
    int              overlap = 0;
    int              double_we = 0;
    logic            prev_we = 1'b0;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .proc_reset   (proc_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: logs every strobe and flags illegal overlaps.
    always @(negedge clk) begin
        if (we) begin
            got_w.push_back({waddr, wdata});
            if (!proc_reset) overlap++;
            if (prev_we) double_we++;
        end
        prev_we = we;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: what a correct loader writes for a given stream.
    task automatic model();
        exp_w.delete();
        exp_n    = (int'(stream[0]) << 8) | int'(stream[1]);
        exp_err  = exp_n > DEPTH;
        exp_done = !exp_err;
        if (!exp_err) begin
            for (int i = 0; i < exp_n; i++) begin
                logic [31:0] d;
                d = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
                exp_w.push_back({AW'(i), d});
            end
        end
    endtask

    task automatic make_program(input int n_hdr, input int n_words);
        stream.delete();
        stream.push_back(8'(n_hdr >> 8));
        stream.push_back(8'(n_hdr));
        for (int i = 0; i < 4 * n_words; i++) stream.push_back(8'($urandom));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check({tag, "_we"}, we, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_proc_reset"}, proc_reset, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_words_loaded"}, words_loaded, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        got_w.delete();
        overlap   = 0;
        double_we = 0;
    endtask

    // Sends stream[first .. last-1]; returns at the negedge after the final transfer.
    task automatic send_bytes(input int first, input int last, input int maxgap);
        for (int i = first; i < last; i++) begin
            int gap;
            int guard;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stream[i];
            guard = 0;
            while (!in_ready && guard < 32) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic finish_check(input string tag);
        model();
        if (!exp_err && exp_n > 0) begin
            check({tag, "_flush_we"}, we, 1);
            check({tag, "_flush_proc_reset"}, proc_reset, 1);
            @(negedge clk);
            check({tag, "_release_proc_reset"}, proc_reset, 0);
            check({tag, "_release_we"}, we, 0);
            @(negedge clk);
        end else begin
            repeat (2) @(negedge clk);
        end
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_proc_reset"}, proc_reset, !exp_done);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_words_loaded"}, words_loaded, exp_err ? 0 : exp_n);
        check({tag, "_write_count"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check($sformatf("%s_write%0d", tag, i), got_w[i], exp_w[i]);
        check({tag, "_overlap"}, overlap, 0);
        check({tag, "_double_we"}, double_we, 0);
    endtask

    initial begin
        logic [15:0] wl_hold;

        // Full-rate 5-word program.
        reset_pulse("rst1");
        make_program(5, 5);
        send_bytes(0, stream.size(), 0);
        finish_check("full_rate");

        // Same program with random stalls and garbage on in_data.
        reset_pulse("rst2");
        send_bytes(0, stream.size(), 3);
        finish_check("stalled");

        // Locked after done: offered bytes are refused.
        wl_hold = words_loaded;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            check("run_in_ready", in_ready, 0);
            check("run_we", we, 0);
        end
        in_valid = 1'b0;
        check("run_words_loaded", words_loaded, wl_hold);

        // Empty program.
        reset_pulse("rst3");
        make_program(0, 0);
        send_bytes(0, 2, 1);
        finish_check("empty");

        // Exactly fills memory.
        reset_pulse("rst4");
        make_program(DEPTH, DEPTH);
        send_bytes(0, stream.size(), 1);
        finish_check("full_mem");
        check("full_mem_last_addr", got_w.size() > 0 ? got_w[got_w.size()-1][AW+31:32] : 0, DEPTH - 1);

        // One word too many: error, bytes refused afterwards.
        reset_pulse("rst5");
        make_program(DEPTH + 1, 0);
        send_bytes(0, 2, 2);
        finish_check("overflow");
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("overflow_in_ready", in_ready, 0);
        check("overflow_no_write", got_w.size(), 0);
        in_valid = 1'b0;

        // Reset after the 2nd byte of word 3, then a fresh one-word program.
        reset_pulse("rst6");
        make_program(5, 5);
        model();
        send_bytes(0, 2 + 4 * 3 + 2, 2);
        check("partial_writes", got_w.size(), 3);
        for (int i = 0; i < 3 && i < got_w.size(); i++)
            check($sformatf("partial_write%0d", i), got_w[i], exp_w[i]);
        reset_pulse("midrst");
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        send_bytes(0, stream.size(), 2);
        check("fresh_wdata", wdata, 32'h1234_5678);
        check("fresh_waddr", waddr, 0);
        finish_check("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
